// File: rtl/sdp_fifo_ctrl_if.sv
// Valid/ready stream pair between producer, FIFO controller and consumer.
// master: the side that produces s_* and consumes m_*; slave: the controller.
interface sdp_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid
    );

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid
    );
endinterface

// File: rtl/sdp_fifo_ctrl.sv
// Streaming FIFO controller in front of a simple dual-port memory with a
// registered read port. Reads are issued ahead of demand into a 2-entry
// output buffer so that one word per cycle flows in and out.
module sdp_fifo_ctrl #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int CNT_WIDTH  = $clog2(DEPTH + 3)
) (
    input  logic                  clk,
    input  logic                  rst,
    sdp_fifo_ctrl_if.slave        bus,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH-1:0] mem_addra,
    output logic [DATA_WIDTH-1:0] mem_dina,
    output logic                  mem_wea,
    output logic [ADDR_WIDTH-1:0] mem_addrb,
    input  logic [DATA_WIDTH-1:0] mem_doutb
);
    localparam int MCW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [MCW-1:0]        mem_cnt;
    logic [MCW-1:0]        mem_cnt_nxt;
    logic                  rd_pend;
    logic [1:0]            obuf_cnt;
    logic [1:0]            obuf_cnt_nxt;
    logic [DATA_WIDTH-1:0] obuf0;
    logic [DATA_WIDTH-1:0] obuf1;
    logic [CNT_WIDTH-1:0]  count_r;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic                  s_rdy;
    logic                  m_vld;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occ;

    // Handshakes: s_ready depends only on registered mem_cnt, never on s_valid.
    assign s_rdy       = !rst && (mem_cnt != MCW'(DEPTH));
    assign m_vld       = !rst && (obuf_cnt != 2'd0);
    assign push        = bus.s_valid && s_rdy;
    assign pop         = m_vld && bus.m_ready;

    assign bus.s_ready = s_rdy;
    assign bus.m_valid = m_vld;
    assign bus.m_data  = m_vld ? obuf0 : '0;

    assign mem_wea     = push;
    assign mem_addra   = wr_ptr;
    assign mem_dina    = bus.s_data;
    assign mem_addrb   = rd_ptr;

    assign count       = rst ? '0 : count_r;
    assign empty       = (count == '0);
    assign full        = !s_rdy;

    // Read-ahead decision: keep buffered plus in-flight words below two after
    // this cycle's pop. mem_cnt > 0 keeps rd_ptr off the word being written.
    always_comb begin
        occ          = {1'b0, obuf_cnt} + {2'b00, rd_pend} - {2'b00, pop};
        issue        = (mem_cnt != '0) && (occ < 3'd2);
        mem_cnt_nxt  = mem_cnt + MCW'(push) - MCW'(issue);
        obuf_cnt_nxt = obuf_cnt + {1'b0, rd_pend} - {1'b0, pop};
        count_nxt    = CNT_WIDTH'(mem_cnt_nxt) + CNT_WIDTH'(issue)
                     + CNT_WIDTH'(obuf_cnt_nxt);
    end

    // Control state: pointers, occupancies and the read-in-flight flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            rd_pend  <= 1'b0;
            obuf_cnt <= 2'd0;
            count_r  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (issue)
                rd_ptr <= rd_ptr + 1'b1;
            mem_cnt  <= mem_cnt_nxt;
            rd_pend  <= issue;
            obuf_cnt <= obuf_cnt_nxt;
            count_r  <= count_nxt;
        end
    end

    // Output buffer data: capture lands at the tail, pop shifts tail to head.
    always_ff @(posedge clk) begin
        if (rd_pend) begin
            if (pop) begin
                if (obuf_cnt == 2'd2) begin
                    obuf0 <= obuf1;
                    obuf1 <= mem_doutb;
                end else begin
                    obuf0 <= mem_doutb;
                end
            end else if (obuf_cnt == 2'd0) begin
                obuf0 <= mem_doutb;
            end else begin
                obuf1 <= mem_doutb;
            end
        end else if (pop) begin
            obuf0 <= obuf1;
        end
    end
endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// Directed bench for sdp_fifo_ctrl with a behavioural registered-read memory.
module tb_sdp_fifo_ctrl;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sdp_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic [AW-1:0] mem_addra;
    logic [DW-1:0] mem_dina;
    logic          mem_wea;
    logic [AW-1:0] mem_addrb;
    logic [DW-1:0] mem_doutb;
    logic [DW-1:0] mem [DEPTH];

    int vectors     = 0;
    int miscompares = 0;

    sdp_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .mem_addra (mem_addra),
        .mem_dina  (mem_dina),
        .mem_wea   (mem_wea),
        .mem_addrb (mem_addrb),
        .mem_doutb (mem_doutb)
    );

    // Simple dual-port memory, read-before-write, 1-cycle registered read.
    always @(posedge clk) begin
        if (mem_wea)
            mem[mem_addra] <= mem_dina;
        mem_doutb <= mem[mem_addrb];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs at the falling edge, then settle before checking.
    task automatic drive(input logic r, input logic sv, input logic [31:0] sd, input logic mr);
        @(negedge clk);
        rst         = r;
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.m_ready = mr;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;

        // Reset held for three cycles with a producer trying to push.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
            chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
            chk("rst_full",    32'(full),        32'd1);
            chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
            chk("rst_count",   32'(count),       32'd0);
            chk("rst_empty",   32'(empty),       32'd1);
            chk("rst_wea",     32'(mem_wea),     32'd0);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("post_rst_s_ready", 32'(bus.s_ready), 32'd1);
        chk("post_rst_full",    32'(full),        32'd0);
        chk("post_rst_empty",   32'(empty),       32'd1);

        // Single word: 3-cycle latency to m_valid.
        drive(1'b0, 1'b1, 32'hA5A5_0001, 1'b1);
        chk("sw_wea",   32'(mem_wea),   32'd1);
        chk("sw_addra", 32'(mem_addra), 32'd0);
        chk("sw_dina",  mem_dina,       32'hA5A5_0001);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("sw_t1_m_valid", 32'(bus.m_valid), 32'd0);
        chk("sw_t1_count",   32'(count),       32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("sw_t2_m_valid", 32'(bus.m_valid), 32'd0);
        chk("sw_t2_addrb",   32'(mem_addrb),   32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("sw_t3_m_valid", 32'(bus.m_valid), 32'd1);
        chk("sw_t3_m_data",  bus.m_data,       32'hA5A5_0001);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("sw_t4_empty",   32'(empty),       32'd1);
        chk("sw_t4_m_valid", 32'(bus.m_valid), 32'd0);

        // Fill with a stalled consumer: DEPTH+2 words fit.
        for (int k = 0; k < DEPTH + 2; k++) begin
            drive(1'b0, 1'b1, 32'(k), 1'b0);
            chk("fill_s_ready", 32'(bus.s_ready), 32'd1);
            chk("fill_addra",   32'(mem_addra),   32'((1 + k) % DEPTH));
        end
        drive(1'b0, 1'b1, 32'h99, 1'b0);
        chk("full_count",   32'(count),       32'd18);
        chk("full_full",    32'(full),        32'd1);
        chk("full_s_ready", 32'(bus.s_ready), 32'd0);
        chk("full_wea",     32'(mem_wea),     32'd0);
        chk("full_m_valid", 32'(bus.m_valid), 32'd1);
        chk("full_m_data",  bus.m_data,       32'd0);

        // Drain in order, one word per cycle.
        for (int k = 0; k < DEPTH + 2; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            chk("drain_m_valid", 32'(bus.m_valid), 32'd1);
            chk("drain_m_data",  bus.m_data,       32'(k));
            if (k == 0)
                chk("drain_s_ready0", 32'(bus.s_ready), 32'd0);
            if (k == 1)
                chk("drain_s_ready1", 32'(bus.s_ready), 32'd1);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("drain_empty",   32'(empty),       32'd1);
        chk("drain_m_valid", 32'(bus.m_valid), 32'd0);

        // Streaming 3*DEPTH words with pointer wrap-around.
        for (int c = 0; c < 3 * DEPTH + 3; c++) begin
            drive(1'b0, (c < 3 * DEPTH), 32'h1000 + 32'(c), 1'b1);
            if (c < 3 * DEPTH) begin
                chk("st_wea",   32'(mem_wea),   32'd1);
                chk("st_addra", 32'(mem_addra), 32'((3 + c) % DEPTH));
            end
            if (c >= 1 && c <= 3 * DEPTH)
                chk("st_addrb", 32'(mem_addrb), 32'((3 + c - 1) % DEPTH));
            if (c >= 3) begin
                chk("st_m_valid", 32'(bus.m_valid), 32'd1);
                chk("st_m_data",  bus.m_data,       32'h1000 + 32'(c - 3));
            end
            if (c == 20)
                chk("st_count", 32'(count), 32'd3);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("st_empty", 32'(empty), 32'd1);

        // Reset mid-burst with a read in flight.
        for (int k = 0; k < 7; k++)
            drive(1'b0, 1'b1, 32'h2000 + 32'(k), 1'b0);
        drive(1'b0, 1'b1, 32'h2007, 1'b1);
        chk("mr_m_valid", 32'(bus.m_valid), 32'd1);
        chk("mr_m_data",  bus.m_data,       32'h2000);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("mr_count", 32'(count), 32'd7);
        rst = 1'b1;
        drive(1'b0, 1'b1, 32'hBEEF_0001, 1'b1);
        chk("mr_post_count",   32'(count),       32'd0);
        chk("mr_post_m_valid", 32'(bus.m_valid), 32'd0);
        chk("mr_post_s_ready", 32'(bus.s_ready), 32'd1);
        chk("mr_post_addra",   32'(mem_addra),   32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mr_t1_m_valid", 32'(bus.m_valid), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mr_t2_m_valid", 32'(bus.m_valid), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mr_t3_m_valid", 32'(bus.m_valid), 32'd1);
        chk("mr_t3_m_data",  bus.m_data,       32'hBEEF_0001);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mr_t4_empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
